// File: rtl/shoup_precompute_pkg.sv
// Shared types and constants for the Shoup operand precompute block.
// Operand width and the precompute FSM states live here so other lanes can reuse them.
package shoup_precompute_pkg;

  localparam int FSIZE = 64;

  typedef enum logic [1:0] {
    SP_IDLE = 2'd0,
    SP_DIV  = 2'd1,
    SP_DONE = 2'd2
  } shoup_pre_state_t;

  // Accept-to-out_valid latency of a legal request at the default width.
  localparam int SHOUP_PRE_LAT = FSIZE + 1;

endpackage

// File: rtl/shoup_precompute_div_step.sv
// One restoring-division step: shift the partial remainder left, subtract p if it fits.
// Purely combinational so a wider-radix variant can chain several per cycle.
module shoup_div_step #(
  parameter int DATA_SIZE = 64
) (
  input  logic [DATA_SIZE:0]   rem,
  input  logic [DATA_SIZE-1:0] p,
  output logic [DATA_SIZE:0]   next_rem,
  output logic                 qbit
);

  logic [DATA_SIZE:0] w_t;

  // rem < p always holds, so the top bit of rem is zero and the shift loses nothing.
  assign w_t      = {rem[DATA_SIZE-1:0], 1'b0};
  assign qbit     = rem[DATA_SIZE] | (w_t >= {1'b0, p});
  assign next_rem = qbit ? (w_t - {1'b0, p}) : w_t;

endmodule

// File: rtl/shoup_precompute.sv
// Produces (w, p, floor(w * 2^DATA_SIZE / p)) for the Shoup multiplier lanes,
// using a bit-serial restoring divider with valid/ready on both sides.
module shoup_precompute
  import shoup_precompute_pkg::*;
#(
  parameter int DATA_SIZE = FSIZE,
  parameter int ID        = 0,
  parameter bit SIM_MODE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_scalar,
  input  logic [DATA_SIZE-1:0] in_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_scalar,
  output logic [DATA_SIZE-1:0] out_p,
  output logic [DATA_SIZE-1:0] out_scalar_div_p,
  output logic                 out_err
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);

  shoup_pre_state_t     r_state;
  shoup_pre_state_t     w_state_next;
  logic [DATA_SIZE:0]   r_rem;
  logic [DATA_SIZE:0]   w_next_rem;
  logic [DATA_SIZE-1:0] r_q;
  logic [DATA_SIZE-1:0] r_scalar;
  logic [DATA_SIZE-1:0] r_p;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err;
  logic                 w_qbit;
  logic                 w_legal;
  logic                 w_accept;

  assign w_legal  = (in_p != '0) && (in_scalar < in_p);
  assign w_accept = in_valid && in_ready;

  shoup_div_step #(
    .DATA_SIZE(DATA_SIZE)
  ) u_step (
    .rem     (r_rem),
    .p       (r_p),
    .next_rem(w_next_rem),
    .qbit    (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SP_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      SP_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_legal ? SP_DIV : SP_DONE;
        end
      end
      SP_DIV: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = SP_DONE;
        end
      end
      SP_DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE first keeps the output handshake and the next accept in separate cycles.
        if (out_ready) begin
          w_state_next = SP_IDLE;
        end
      end
      default: w_state_next = SP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_q      <= '0;
      r_scalar <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        SP_IDLE: begin
          if (in_valid) begin
            r_scalar <= in_scalar;
            r_p      <= in_p;
            r_q      <= '0;
            r_rem    <= {1'b0, in_scalar};
            r_cnt    <= CNT_W'(DATA_SIZE);
            r_err    <= !w_legal;
          end
        end
        SP_DIV: begin
          r_rem <= w_next_rem;
          r_q   <= {r_q[DATA_SIZE-2:0], w_qbit};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        SP_DONE: begin
          if (out_ready) begin
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (SIM_MODE && !rst && w_accept && !w_legal) begin
      $error("shoup_precompute[%0d]: illegal request w=%0h p=%0h", ID, in_scalar, in_p);
    end
  end

  assign out_scalar       = r_scalar;
  assign out_p            = r_p;
  assign out_scalar_div_p = r_q;
  assign out_err          = r_err;

endmodule

// File: tb/tb_shoup_precompute.sv
// Directed bench for shoup_precompute: an 8-bit and a 64-bit instance share one clock.
module tb_shoup_precompute;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 8-bit instance
  logic       d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready, d8_out_err;
  logic [7:0] d8_in_scalar, d8_in_p, d8_out_scalar, d8_out_p, d8_out_q;

  // 64-bit instance
  logic        d64_in_valid, d64_in_ready, d64_out_valid, d64_out_ready, d64_out_err;
  logic [63:0] d64_in_scalar, d64_in_p, d64_out_scalar, d64_out_p, d64_out_q;

  shoup_precompute #(.DATA_SIZE(8), .ID(1), .SIM_MODE(1'b0)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .in_scalar(d8_in_scalar), .in_p(d8_in_p),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .out_scalar(d8_out_scalar), .out_p(d8_out_p),
    .out_scalar_div_p(d8_out_q), .out_err(d8_out_err)
  );

  shoup_precompute #(.DATA_SIZE(64), .ID(2), .SIM_MODE(1'b0)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(d64_in_valid), .in_ready(d64_in_ready),
    .in_scalar(d64_in_scalar), .in_p(d64_in_p),
    .out_valid(d64_out_valid), .out_ready(d64_out_ready),
    .out_scalar(d64_out_scalar), .out_p(d64_out_p),
    .out_scalar_div_p(d64_out_q), .out_err(d64_out_err)
  );

  // One full request/response on the 8-bit instance with inline checks.
  task automatic run8(input logic [7:0] w, input logic [7:0] p, input logic [7:0] exp_q,
                      input logic exp_err, input int exp_lat);
    int cyc;
    @(posedge clk); #1;
    d8_in_scalar = w; d8_in_p = p; d8_in_valid = 1'b1;
    n_vec++;
    if (d8_in_ready !== 1'b1) begin
      n_err++; $display("FAIL run8_in_ready w=%0d p=%0d got=%b want=1", w, p, d8_in_ready);
    end
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    cyc = 1;
    n_vec++;
    if (d8_in_ready !== 1'b0) begin
      n_err++; $display("FAIL run8_busy w=%0d p=%0d in_ready got=%b want=0", w, p, d8_in_ready);
    end
    while (d8_out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    n_vec++;
    if (cyc != exp_lat) begin
      n_err++; $display("FAIL run8_latency w=%0d p=%0d got=%0d want=%0d", w, p, cyc, exp_lat);
    end
    n_vec++;
    if (d8_out_q !== exp_q || d8_out_err !== exp_err || d8_out_scalar !== w || d8_out_p !== p) begin
      n_err++;
      $display("FAIL run8_result w=%0d p=%0d got q=%0d err=%b s=%0d p=%0d want q=%0d err=%b",
               w, p, d8_out_q, d8_out_err, d8_out_scalar, d8_out_p, exp_q, exp_err);
    end
    $display("txn8 w=%0d p=%0d q=%0d err=%b lat=%0d", w, p, d8_out_q, d8_out_err, cyc);
    d8_out_ready = 1'b1;
    @(posedge clk); #1;
    d8_out_ready = 1'b0;
    n_vec++;
    if (d8_out_valid !== 1'b0 || d8_in_ready !== 1'b1 || d8_out_err !== 1'b0) begin
      n_err++;
      $display("FAIL run8_release got valid=%b ready=%b err=%b want 0/1/0",
               d8_out_valid, d8_in_ready, d8_out_err);
    end
  endtask

  // One request/response on the 64-bit instance; returns the observed quotient.
  task automatic run64(input logic [63:0] w, input logic [63:0] p, input logic [63:0] exp_q,
                       output logic [63:0] got_q);
    int cyc;
    @(posedge clk); #1;
    d64_in_scalar = w; d64_in_p = p; d64_in_valid = 1'b1;
    @(posedge clk); #1;
    d64_in_valid = 1'b0;
    cyc = 1;
    while (d64_out_valid !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    n_vec++;
    if (cyc != 65) begin
      n_err++; $display("FAIL run64_latency w=%0h got=%0d want=65", w, cyc);
    end
    n_vec++;
    if (d64_out_q !== exp_q || d64_out_err !== 1'b0) begin
      n_err++; $display("FAIL run64_result w=%0h p=%0h got q=%0h err=%b want q=%0h err=0",
                        w, p, d64_out_q, d64_out_err, exp_q);
    end
    got_q = d64_out_q;
    $display("txn64 w=%0h p=%0h q=%0h lat=%0d", w, p, d64_out_q, cyc);
    d64_out_ready = 1'b1;
    @(posedge clk); #1;
    d64_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if (d8_in_ready !== 1'b1 || d8_out_valid !== 1'b0 || d8_out_err !== 1'b0 ||
        d8_out_q !== 8'd0 || d8_out_scalar !== 8'd0 || d8_out_p !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state got ready=%b valid=%b err=%b q=%0d s=%0d p=%0d want 1/0/0/0/0/0",
               d8_in_ready, d8_out_valid, d8_out_err, d8_out_q, d8_out_scalar, d8_out_p);
    end
    n_vec++;
    if (d64_in_ready !== 1'b1 || d64_out_valid !== 1'b0 || d64_out_q !== 64'd0) begin
      n_err++; $display("FAIL reset_state64 got ready=%b valid=%b q=%0h want 1/0/0",
                        d64_in_ready, d64_out_valid, d64_out_q);
    end
    $display("txn reset checked");
  endtask

  task automatic test_basic();
    run8(8'd3, 8'd7, 8'd109, 1'b0, 9);
  endtask

  task automatic test_boundaries();
    run8(8'd250, 8'd251, 8'd254, 1'b0, 9);
    run8(8'd0,   8'd251, 8'd0,   1'b0, 9);
    run8(8'd0,   8'd1,   8'd0,   1'b0, 9);
    run8(8'd254, 8'd255, 8'd254, 1'b0, 9);
  endtask

  task automatic test_illegal();
    run8(8'd7, 8'd7, 8'd0, 1'b1, 1);
    run8(8'd5, 8'd0, 8'd0, 1'b1, 1);
  endtask

  task automatic test_wide();
    logic [63:0]  q;
    logic [127:0] a, hi, r, two_p;
    int bad;
    run64(64'd1, 64'd3, 64'h5555_5555_5555_5555, q);
    // Shoup reduction property: a*w - floor(a*q/2^64)*p lands in [0, 2p).
    bad = 0;
    two_p = 128'd6;
    for (int i = 0; i < 1000; i++) begin
      a  = {64'd0, $urandom, $urandom};
      hi = (a * {64'd0, q}) >> 64;
      r  = a - hi * 128'd3;
      if (r >= two_p) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL wide_shoup_range out_of_range=%0d want=0 (q=%0h)", bad, q);
    end
    run64(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, q);
  endtask

  task automatic test_back_pressure();
    int cyc;
    int stable_bad;
    @(posedge clk); #1;
    d8_in_scalar = 8'd3; d8_in_p = 8'd7; d8_in_valid = 1'b1;
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    cyc = 1;
    while (d8_out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      d8_in_valid = 1'b1;
      d8_in_scalar = 8'(i + 1); d8_in_p = 8'(i + 100);
      @(posedge clk); #1;
      if (d8_out_valid !== 1'b1 || d8_in_ready !== 1'b0 || d8_out_q !== 8'd109 ||
          d8_out_scalar !== 8'd3 || d8_out_p !== 8'd7) stable_bad++;
    end
    n_vec++;
    if (stable_bad != 0) begin
      n_err++; $display("FAIL backpressure_hold unstable_cycles=%0d want=0 (q=%0d)", stable_bad, d8_out_q);
    end
    d8_in_scalar = 8'd250; d8_in_p = 8'd251;
    d8_out_ready = 1'b1;
    @(posedge clk); #1;
    d8_out_ready = 1'b0;
    n_vec++;
    if (d8_out_valid !== 1'b0 || d8_in_ready !== 1'b1) begin
      n_err++; $display("FAIL backpressure_release got valid=%b ready=%b want 0/1",
                        d8_out_valid, d8_in_ready);
    end
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    cyc = 1;
    while (d8_out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    n_vec++;
    if (cyc != 9 || d8_out_q !== 8'd254 || d8_out_scalar !== 8'd250) begin
      n_err++; $display("FAIL backpressure_next got lat=%0d q=%0d s=%0d want 9/254/250",
                        cyc, d8_out_q, d8_out_scalar);
    end
    $display("txn8 backpressure next q=%0d lat=%0d", d8_out_q, cyc);
    d8_out_ready = 1'b1;
    @(posedge clk); #1;
    d8_out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    d8_in_scalar = 8'd3; d8_in_p = 8'd7; d8_in_valid = 1'b1;
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (d8_in_ready !== 1'b1 || d8_out_valid !== 1'b0 || d8_out_err !== 1'b0 ||
        d8_out_q !== 8'd0 || d8_out_scalar !== 8'd0 || d8_out_p !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset got ready=%b valid=%b err=%b q=%0d s=%0d p=%0d want 1/0/0/0/0/0",
               d8_in_ready, d8_out_valid, d8_out_err, d8_out_q, d8_out_scalar, d8_out_p);
    end
    $display("txn8 mid-operation reset checked");
    run8(8'd3, 8'd7, 8'd109, 1'b0, 9);
  endtask

  initial begin
    rst = 1'b1;
    d8_in_valid = 1'b0; d8_out_ready = 1'b0; d8_in_scalar = '0; d8_in_p = '0;
    d64_in_valid = 1'b0; d64_out_ready = 1'b0; d64_in_scalar = '0; d64_in_p = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_illegal();
    test_wide();
    test_back_pressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
